// File: rtl/led_step_gen.sv
// Step-enable generator for the running-LED shifter: a four-speed prescaler with
// a pause control, driven by two synchronised and debounced push-buttons.
module led_step_gen #(
  parameter int BASE_DIV  = 5000000,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic       step,
  output logic [1:0] speed,
  output logic       running
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] P0_LAST = CNT_W'(BASE_DIV - 1);
  localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(BASE_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(BASE_DIV / 4 - 1);
  localparam logic [CNT_W-1:0] P3_LAST = CNT_W'(BASE_DIV / 8 - 1);

  // Bit 0 is the speed button, bit 1 the pause button.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_pause, btn_speed};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_btn
      logic             meta_q;
      logic             sync_q;
      logic             deb_q;
      logic             deb_d;
      logic             press_q;
      logic             press_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Any cycle where sync agrees with deb restarts the stability count.
      always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        if (sync_q != deb_q) begin
          if (cnt_q == DB_LAST) begin
            deb_d = ~deb_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        press_d = deb_d & ~deb_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_q  <= 1'b0;
          sync_q  <= 1'b0;
          deb_q   <= 1'b0;
          press_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          meta_q  <= btn_raw[gi];
          sync_q  <= meta_q;
          deb_q   <= deb_d;
          press_q <= press_d;
          cnt_q   <= cnt_d;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic             speed_ev;
  logic             pause_ev;
  logic [1:0]       speed_q;
  logic [1:0]       speed_d;
  logic             running_q;
  logic             running_d;
  logic             step_q;
  logic             step_d;
  logic [CNT_W-1:0] pre_q;
  logic [CNT_W-1:0] pre_d;
  logic [CNT_W-1:0] per_last;

  assign speed_ev = press[0];
  assign pause_ev = press[1];

  always_comb begin
    case (speed_q)
      2'd0:    per_last = P0_LAST;
      2'd1:    per_last = P1_LAST;
      2'd2:    per_last = P2_LAST;
      default: per_last = P3_LAST;
    endcase
  end

  // Either button event freezes counting for that cycle; a speed event also
  // restarts the period so the counter can never sit above the new limit.
  always_comb begin
    speed_d   = speed_q;
    running_d = running_q;
    pre_d     = pre_q;
    step_d    = 1'b0;
    if (speed_ev) begin
      speed_d = speed_q + 2'd1;
      pre_d   = '0;
    end
    if (pause_ev) begin
      running_d = ~running_q;
    end
    if (!speed_ev && !pause_ev && running_q) begin
      if (pre_q == per_last) begin
        pre_d  = '0;
        step_d = 1'b1;
      end else begin
        pre_d = pre_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q   <= 2'd0;
      running_q <= 1'b1;
      step_q    <= 1'b0;
      pre_q     <= '0;
    end else begin
      speed_q   <= speed_d;
      running_q <= running_d;
      step_q    <= step_d;
      pre_q     <= pre_d;
    end
  end

  assign step    = step_q;
  assign speed   = speed_q;
  assign running = running_q;

endmodule

// File: tb/tb_led_step_gen.sv
// Directed bench for led_step_gen at BASE_DIV=16, DB_CYCLES=4: step periods,
// button latency, debounce rejection, pause hold/resume and async reset.
module tb_led_step_gen;

  logic       clk;
  logic       reset;
  logic       btn_speed;
  logic       btn_pause;
  logic       step;
  logic [1:0] speed;
  logic       running;

  int         checks;
  int         errors;
  logic [1:0] exp_speed;
  logic       exp_running;

  led_step_gen #(
    .BASE_DIV (16),
    .DB_CYCLES(4),
    .CNT_W    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_speed(btn_speed),
    .btn_pause(btn_pause),
    .step     (step),
    .speed    (speed),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Ticks until step is seen high; n is the tick count, or -1 on timeout.
  task automatic wait_step(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (step === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Raw rise lands before edge 0; the event takes effect on edge 6.
  task automatic do_press(input logic s, input logic p, input int extra);
    btn_speed = s;
    btn_pause = p;
    repeat (6) tick();
    check("press_pre_speed", 32'(speed), 32'(exp_speed));
    check("press_pre_running", 32'(running), 32'(exp_running));
    tick();
    if (s) exp_speed = exp_speed + 2'd1;
    if (p) exp_running = ~exp_running;
    check("press_post_speed", 32'(speed), 32'(exp_speed));
    check("press_post_running", 32'(running), 32'(exp_running));
    repeat (extra) tick();
    btn_speed = 1'b0;
    btn_pause = 1'b0;
  endtask

  initial begin
    int   n;
    logic quiet_bad;
    int   per [4];
    per[0] = 16;
    per[1] = 8;
    per[2] = 4;
    per[3] = 2;
    checks      = 0;
    errors      = 0;
    exp_speed   = 2'd0;
    exp_running = 1'b1;
    reset       = 1'b1;
    btn_speed   = 1'b0;
    btn_pause   = 1'b0;

    // 1: reset state and base period
    idle(3);
    check("reset_step", 32'(step), 32'd0);
    check("reset_speed", 32'(speed), 32'd0);
    check("reset_running", 32'(running), 32'd1);
    reset = 1'b0;
    wait_step(n);
    check("first_step_delay", 32'(n), 32'd16);
    tick();
    check("pulse_width", 32'(step), 32'd0);
    wait_step(n);
    check("period_speed0", 32'(n + 1), 32'd16);
    wait_step(n);
    check("period_speed0_again", 32'(n), 32'd16);

    // 2: four clean speed presses, the last wrapping back to 0
    for (int k = 1; k <= 4; k++) begin
      idle(8);
      do_press(1'b1, 1'b0, 3);
      wait_step(n);
      wait_step(n);
      check("period_after_speed", 32'(n), 32'(per[k % 4]));
    end

    // 3: bounce shorter than the debounce window is ignored
    for (int i = 0; i < 30; i++) begin
      btn_speed = ((i / 2) % 2 == 0);
      tick();
    end
    btn_speed = 1'b0;
    idle(8);
    check("bounce_speed", 32'(speed), 32'd0);
    wait_step(n);
    wait_step(n);
    check("bounce_period", 32'(n), 32'd16);

    // 4: pause lands on prescaler value 11, resume steps after 16-11 cycles
    wait_step(n);
    idle(5);
    do_press(1'b0, 1'b1, 3);
    quiet_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (step !== 1'b0) quiet_bad = 1'b1;
    end
    check("pause_quiet", 32'(quiet_bad), 32'd0);
    do_press(1'b0, 1'b1, 0);
    wait_step(n);
    check("resume_first_step", 32'(n), 32'd5);

    // 5: simultaneous presses; prescaler cleared, shown by the resume delay
    idle(3);
    do_press(1'b1, 1'b1, 0);
    check("both_no_step", 32'(step), 32'd0);
    idle(10);
    do_press(1'b0, 1'b1, 0);
    wait_step(n);
    check("both_cleared_resume", 32'(n), 32'd8);
    idle(8);
    do_press(1'b1, 1'b1, 0);
    idle(8);
    check("pre_reset_speed", 32'(speed), 32'd2);
    check("pre_reset_running", 32'(running), 32'd0);

    // 6: asynchronous reset during a bounce sequence
    btn_speed = 1'b1;
    idle(4);
    reset = 1'b1;
    #1;
    check("async_reset_speed", 32'(speed), 32'd0);
    check("async_reset_running", 32'(running), 32'd1);
    check("async_reset_step", 32'(step), 32'd0);
    btn_speed = 1'b0;
    tick();
    btn_speed = 1'b1;
    idle(2);
    btn_speed = 1'b0;
    reset = 1'b0;
    wait_step(n);
    check("post_reset_first_step", 32'(n), 32'd16);
    wait_step(n);
    check("post_reset_period", 32'(n), 32'd16);
    check("post_reset_speed", 32'(speed), 32'd0);
    check("post_reset_running", 32'(running), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
